// File: rtl/kamus_pkg.sv
// Shared types for the kamus-v CSR counter unit: CSR address enum,
// system funct2 encoding and the read/modify/write helper.
package kamus_pkg;

   typedef enum logic [1:0] {
      F2_PRIV  = 2'b00,
      F2_CSRRW = 2'b01,
      F2_CSRRS = 2'b10,
      F2_CSRRC = 2'b11
   } funct2_system_t;

   typedef enum logic [11:0] {
      MCOUNTINHIBIT  = 12'h320,
      MTIMECMP       = 12'h7C1,
      MTIMECMPH      = 12'h7C2,
      MHPMCOUNTER3   = 12'hB03,
      MHPMCOUNTER4   = 12'hB04,
      MHPMCOUNTER5   = 12'hB05,
      MHPMCOUNTER6   = 12'hB06,
      MHPMCOUNTER7   = 12'hB07,
      MHPMCOUNTER8   = 12'hB08,
      MHPMCOUNTER9   = 12'hB09,
      MHPMCOUNTER10  = 12'hB0A,
      MHPMCOUNTER3H  = 12'hB83,
      MHPMCOUNTER4H  = 12'hB84,
      MHPMCOUNTER5H  = 12'hB85,
      MHPMCOUNTER6H  = 12'hB86,
      MHPMCOUNTER7H  = 12'hB87,
      MHPMCOUNTER8H  = 12'hB88,
      MHPMCOUNTER9H  = 12'hB89,
      MHPMCOUNTER10H = 12'hB8A,
      CYCLE          = 12'hC00,
      TIME           = 12'hC01,
      INSTRET        = 12'hC02,
      HPMCOUNTER3    = 12'hC03,
      HPMCOUNTER4    = 12'hC04,
      HPMCOUNTER5    = 12'hC05,
      HPMCOUNTER6    = 12'hC06,
      HPMCOUNTER7    = 12'hC07,
      HPMCOUNTER8    = 12'hC08,
      HPMCOUNTER9    = 12'hC09,
      HPMCOUNTER10   = 12'hC0A,
      CYCLEH         = 12'hC80,
      TIMEH          = 12'hC81,
      INSTRETH       = 12'hC82,
      HPMCOUNTER3H   = 12'hC83,
      HPMCOUNTER4H   = 12'hC84,
      HPMCOUNTER5H   = 12'hC85,
      HPMCOUNTER6H   = 12'hC86,
      HPMCOUNTER7H   = 12'hC87,
      HPMCOUNTER8H   = 12'hC88,
      HPMCOUNTER9H   = 12'hC89,
      HPMCOUNTER10H  = 12'hC8A,
      MCYCLE         = 12'hF00,
      MTIME          = 12'hF01,
      MINSTRET       = 12'hF02,
      MCYCLEH        = 12'hF80,
      MTIMEH         = 12'hF81,
      MINSTRETH      = 12'hF82
   } csr_e;

   // Counter slots share the CSR low-index numbering: 0 cycle, 1 time, 2 instret, 3+ HPM.
   localparam int NUM_BASE_CNT = 3;

   function automatic logic [31:0] csr_rmw(input logic [31:0] old, input logic [31:0] wdata,
                                           input funct2_system_t op);
      case (op)
         F2_CSRRW: return wdata;
         F2_CSRRS: return old | wdata;
         F2_CSRRC: return old & ~wdata;
         default:  return old;
      endcase
   endfunction

   // Writable mcountinhibit bits: CY, IR and one per implemented HPM counter.
   function automatic logic [31:0] inh_mask(input int num_hpm);
      logic [31:0] m;
      m = 32'h1;
      for (int k = 2; k <= 2 + num_hpm; k++) m[k] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/kamus_csr_counter.sv
// One COUNTER_W-bit CSR counter: 32-bit half writes take priority over increment.
module kamus_csr_counter #(
   parameter int W = 64
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc,
   input  logic         wr_lo,
   input  logic         wr_hi,
   input  logic [31:0]  wdata,
   output logic [W-1:0] value
);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         value <= '0;
      end else if (wr_lo) begin
         value[31:0] <= wdata;
      end else if (wr_hi) begin
         value[W-1:32] <= wdata[W-33:0];
      end else if (inc) begin
         value <= value + 1'b1;
      end
   end

endmodule

// File: rtl/kamus_csr_counters.sv
// Machine counter/timer CSR unit: mcycle, mtime/mtimecmp, minstret, HPM bank,
// mcountinhibit. Accesses are accepted every cycle and answered one cycle later.
module kamus_csr_counters
   import kamus_pkg::*;
#(
   parameter int COUNTER_W = 64,
   parameter int NUM_HPM   = 2,
   parameter int TIME_DIV  = 1
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 csr_req_i,
   input  logic                                 csr_we_i,
   input  logic [1:0]                           csr_op_i,
   input  logic [11:0]                          csr_addr_i,
   input  logic [31:0]                          csr_wdata_i,
   output logic [31:0]                          csr_rdata_o,
   output logic                                 csr_valid_o,
   output logic                                 csr_illegal_o,
   input  logic                                 instr_retired_i,
   input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event_i,
   output logic                                 timer_irq_o
);

   localparam int          NCNT     = NUM_BASE_CNT + NUM_HPM;
   localparam logic [31:0] INH_MASK = inh_mask(NUM_HPM);

   logic [COUNTER_W-1:0] cnt_q [NCNT];
   logic [COUNTER_W-1:0] cmp_q;
   logic [31:0]          inh_q;
   logic [7:0]           presc_q;
   logic                 tick;

   logic        hit, ro, is_cnt, is_cmp, is_inh, sel_hi, illegal, wr_en;
   logic [6:0]  sel_idx;
   logic [COUNTER_W-1:0] full;
   logic [63:0] full64;
   logic [31:0] rd_val, new_val;
   logic [NCNT-1:0] inc, wr_lo, wr_hi;

   assign tick = (presc_q == 8'(TIME_DIV - 1));

   // Address decode: Fxx/Bxx/Cxx pages carry the counter slot in bits 6:0, half in bit 7.
   always_comb begin
      hit     = 1'b0;
      ro      = 1'b0;
      is_cnt  = 1'b0;
      is_cmp  = 1'b0;
      is_inh  = 1'b0;
      sel_hi  = csr_addr_i[7];
      sel_idx = csr_addr_i[6:0];
      case (csr_addr_i)
         MCOUNTINHIBIT: begin hit = 1'b1; is_inh = 1'b1; end
         MTIMECMP:      begin hit = 1'b1; is_cmp = 1'b1; sel_hi = 1'b0; end
         MTIMECMPH:     begin hit = 1'b1; is_cmp = 1'b1; sel_hi = 1'b1; end
         default: begin
            if (csr_addr_i[11:8] == 4'hF && sel_idx < 7'(NUM_BASE_CNT)) begin
               hit = 1'b1; is_cnt = 1'b1;
            end else if (csr_addr_i[11:8] == 4'hB && sel_idx >= 7'(NUM_BASE_CNT)
                         && sel_idx < 7'(NCNT)) begin
               hit = 1'b1; is_cnt = 1'b1;
            end else if (csr_addr_i[11:8] == 4'hC && sel_idx < 7'(NCNT)) begin
               hit = 1'b1; is_cnt = 1'b1; ro = 1'b1;
            end
         end
      endcase
   end

   assign illegal = ~hit | (csr_we_i & ro);
   assign wr_en   = csr_req_i & csr_we_i & ~illegal;

   always_comb begin
      full = cmp_q;
      if (is_cnt) begin
         full = '0;
         for (int k = 0; k < NCNT; k++)
            if (sel_idx == 7'(k)) full = cnt_q[k];
      end
   end

   assign full64  = 64'(full);
   assign rd_val  = is_inh ? inh_q : (sel_hi ? full64[63:32] : full64[31:0]);
   assign new_val = csr_rmw(rd_val, csr_wdata_i, funct2_system_t'(csr_op_i));

   always_comb begin
      inc    = '0;
      inc[0] = ~inh_q[0];
      inc[1] = tick;
      inc[2] = instr_retired_i & ~inh_q[2];
      for (int i = 0; i < NUM_HPM; i++)
         inc[NUM_BASE_CNT+i] = hpm_event_i[i] & ~inh_q[NUM_BASE_CNT+i];
      wr_lo = '0;
      wr_hi = '0;
      for (int k = 0; k < NCNT; k++) begin
         wr_lo[k] = wr_en & is_cnt & (sel_idx == 7'(k)) & ~sel_hi;
         wr_hi[k] = wr_en & is_cnt & (sel_idx == 7'(k)) & sel_hi;
      end
   end

   for (genvar k = 0; k < NCNT; k++) begin : g_cnt
      kamus_csr_counter #(.W(COUNTER_W)) u_cnt (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .inc   (inc[k]),
         .wr_lo (wr_lo[k]),
         .wr_hi (wr_hi[k]),
         .wdata (new_val),
         .value (cnt_q[k])
      );
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         presc_q       <= '0;
         inh_q         <= '0;
         cmp_q         <= '1;
         csr_valid_o   <= 1'b0;
         csr_rdata_o   <= '0;
         csr_illegal_o <= 1'b0;
         timer_irq_o   <= 1'b0;
      end else begin
         presc_q       <= tick ? 8'd0 : presc_q + 8'd1;
         timer_irq_o   <= (cnt_q[1] >= cmp_q);
         csr_valid_o   <= csr_req_i;
         csr_illegal_o <= csr_req_i & illegal;
         csr_rdata_o   <= (csr_req_i & ~illegal) ? rd_val : 32'd0;
         if (wr_en && is_inh) inh_q <= new_val & INH_MASK;
         if (wr_en && is_cmp) begin
            if (sel_hi) cmp_q[COUNTER_W-1:32] <= new_val[COUNTER_W-33:0];
            else        cmp_q[31:0]           <= new_val;
         end
      end
   end

endmodule

// File: tb/tb_kamus_csr_counters.sv
// Bench for kamus_csr_counters: directed scenarios plus random CSR traffic,
// checked cycle by cycle against an arithmetic model of the counter CSRs.
module tb_kamus_csr_counters;

   localparam int CW = 48;
   localparam int NH = 2;
   localparam int TD = 4;
   localparam longint unsigned MASK = (64'd1 << CW) - 64'd1;

   logic        clk;
   logic        rst_i, csr_req_i, csr_we_i, instr_retired_i;
   logic [1:0]  csr_op_i, hpm_event_i;
   logic [11:0] csr_addr_i;
   logic [31:0] csr_wdata_i, csr_rdata_o;
   logic        csr_valid_o, csr_illegal_o, timer_irq_o;

   kamus_csr_counters #(.COUNTER_W(CW), .NUM_HPM(NH), .TIME_DIV(TD)) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .csr_req_i       (csr_req_i),
      .csr_we_i        (csr_we_i),
      .csr_op_i        (csr_op_i),
      .csr_addr_i      (csr_addr_i),
      .csr_wdata_i     (csr_wdata_i),
      .csr_rdata_o     (csr_rdata_o),
      .csr_valid_o     (csr_valid_o),
      .csr_illegal_o   (csr_illegal_o),
      .instr_retired_i (instr_retired_i),
      .hpm_event_i     (hpm_event_i),
      .timer_irq_o     (timer_irq_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // model state: slot 0 cycle, 1 time, 2 instret, 3.. HPM
   longint unsigned m_cnt [3+NH];
   longint unsigned m_cmp;
   logic [31:0]     m_inh;
   int              m_presc;
   logic [32:0]     exp_q [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void m_decode(input logic [11:0] a, output bit hit, output bit ro,
                                    output int kind, output int idx, output bit hi);
      hit = 0; ro = 0; kind = 0; idx = int'(a[6:0]); hi = a[7];
      if (a == 12'h320) begin
         hit = 1; kind = 2;
      end else if (a == 12'h7C1 || a == 12'h7C2) begin
         hit = 1; kind = 1; hi = (a == 12'h7C2);
      end else begin
         case (a[11:8])
            4'hF: hit = (idx < 3);
            4'hB: hit = (idx >= 3 && idx < 3 + NH);
            4'hC: begin hit = (idx < 3 + NH); ro = 1; end
            default: hit = 0;
         endcase
      end
   endfunction

   function automatic logic [31:0] half(input longint unsigned v, input bit hi);
      return hi ? v[63:32] : v[31:0];
   endfunction

   // driver: apply one cycle of inputs, advance the model, check outputs
   task automatic step(input bit rst, input bit req, input bit we, input logic [1:0] op,
                       input logic [11:0] addr, input logic [31:0] wd,
                       input bit ret, input logic [1:0] ev);
      bit hit, ro, hi, ill, push, e_irq, tick;
      int kind, idx;
      logic [31:0] old32, nv;
      longint unsigned v;
      rst_i = rst; csr_req_i = req; csr_we_i = we; csr_op_i = op;
      csr_addr_i = addr; csr_wdata_i = wd; instr_retired_i = ret; hpm_event_i = ev;
      @(posedge clk);
      push = 0; e_irq = 0;
      if (rst) begin
         foreach (m_cnt[k]) m_cnt[k] = 0;
         m_cmp = MASK; m_inh = 0; m_presc = 0;
      end else begin
         e_irq = (m_cnt[1] >= m_cmp);
         m_decode(addr, hit, ro, kind, idx, hi);
         ill = !hit || (we && ro);
         case (kind)
            0: old32 = hit ? half(m_cnt[idx], hi) : 32'd0;
            1: old32 = half(m_cmp, hi);
            default: old32 = m_inh;
         endcase
         if (req) begin
            push = 1;
            exp_q.push_back({ill, ill ? 32'd0 : old32});
         end
         case (op)
            2'b01: nv = wd;
            2'b10: nv = old32 | wd;
            2'b11: nv = old32 & ~wd;
            default: nv = old32;
         endcase
         tick = (m_presc == TD - 1);
         m_presc = tick ? 0 : m_presc + 1;
         for (int k = 0; k < 3 + NH; k++) begin
            bit bump;
            if (k == 0)      bump = !m_inh[0];
            else if (k == 1) bump = tick;
            else if (k == 2) bump = ret && !m_inh[2];
            else             bump = ev[k-3] && !m_inh[k];
            if (req && we && !ill && kind == 0 && idx == k) begin
               v = m_cnt[k];
               if (hi) v = {nv, v[31:0]};
               else    v = {v[63:32], nv};
               m_cnt[k] = v & MASK;
            end else if (bump) begin
               m_cnt[k] = (m_cnt[k] + 1) & MASK;
            end
         end
         if (req && we && !ill && kind == 1) begin
            v = m_cmp;
            if (hi) v = {nv, v[31:0]};
            else    v = {v[63:32], nv};
            m_cmp = v & MASK;
         end
         if (req && we && !ill && kind == 2) m_inh = nv & 32'h0000_001D;
      end
      #1;
      check("valid", {63'd0, csr_valid_o}, {63'd0, push});
      if (push) begin
         logic [32:0] e;
         e = exp_q.pop_front();
         if (csr_valid_o) begin
            check("rdata", {32'd0, csr_rdata_o}, {32'd0, e[31:0]});
            check("illegal", {63'd0, csr_illegal_o}, {63'd0, e[32]});
         end
      end
      check("irq", {63'd0, timer_irq_o}, {63'd0, e_irq});
   endtask

   task automatic idle(input int n, input bit ret, input logic [1:0] ev);
      for (int i = 0; i < n; i++) step(0, 0, 0, 2'b01, 12'h000, 32'd0, ret, ev);
   endtask

   task automatic wr(input logic [11:0] addr, input logic [31:0] wd);
      step(0, 1, 1, 2'b01, addr, wd, 0, 2'b00);
   endtask

   task automatic rd(input logic [11:0] addr);
      step(0, 1, 0, 2'b10, addr, 32'd0, 0, 2'b00);
   endtask

   logic [11:0] addr_tbl [30] = '{
      12'hF00, 12'hF80, 12'hF01, 12'hF81, 12'hF02, 12'hF82, 12'h7C1, 12'h7C2,
      12'h320, 12'hB03, 12'hB83, 12'hB04, 12'hB84, 12'hC00, 12'hC01, 12'hC02,
      12'hC03, 12'hC04, 12'hC80, 12'hC81, 12'hC82, 12'hC83, 12'hC84, 12'hB05,
      12'hB85, 12'hC05, 12'hF03, 12'h7C0, 12'h321, 12'h000
   };

   initial begin
      rst_i = 1; csr_req_i = 0; csr_we_i = 0; csr_op_i = 2'b01; csr_addr_i = '0;
      csr_wdata_i = '0; instr_retired_i = 0; hpm_event_i = '0;

      // reset state
      step(1, 0, 0, 2'b01, 12'h000, 32'd0, 0, 2'b00);
      step(1, 0, 0, 2'b01, 12'h000, 32'd0, 0, 2'b00);
      check("rst_rdata", {32'd0, csr_rdata_o}, 64'd0);
      check("rst_illegal", {63'd0, csr_illegal_o}, 64'd0);

      // mcycle read on the tenth cycle after reset release
      idle(9, 0, 2'b00);
      step(0, 1, 0, 2'b10, 12'hF00, 32'd0, 0, 2'b00);
      check("plan_mcycle9", {32'd0, csr_rdata_o}, 64'd9);
      idle(1, 0, 2'b00);
      check("plan_valid_pulse", {63'd0, csr_valid_o}, 64'd0);

      // wrap at COUNTER_W
      wr(12'hF00, 32'hFFFF_FFFF);
      wr(12'hF80, 32'hFFFF_FFFF);
      rd(12'hF00);
      check("plan_wrap_lo", {32'd0, csr_rdata_o}, 64'hFFFF_FFFF);
      rd(12'hF80);
      check("plan_wrap_hi", {32'd0, csr_rdata_o}, 64'd0);

      // inhibit cycle and instret, HPM3 still counts
      wr(12'h320, 32'h5);
      wr(12'hB03, 32'd0);
      wr(12'hB83, 32'd0);
      for (int i = 0; i < 100; i++) step(0, 0, 0, 2'b01, 12'h000, 32'd0, 1, {1'b0, (i % 13) == 0 && i < 91});
      rd(12'hB03);
      check("plan_hpm3_7", {32'd0, csr_rdata_o}, 64'd7);
      rd(12'hC00);
      wr(12'h320, 32'h0);

      // timer interrupt
      wr(12'hF81, 32'd0);
      wr(12'hF01, 32'd0);
      wr(12'h7C2, 32'd0);
      wr(12'h7C1, 32'd3);
      idle(20, 0, 2'b00);
      check("plan_irq_set", {63'd0, timer_irq_o}, 64'd1);
      wr(12'h7C1, 32'hFFFF_FFFF);
      wr(12'h7C2, 32'hFFFF_FFFF);
      idle(1, 0, 2'b00);
      check("plan_irq_clr", {63'd0, timer_irq_o}, 64'd0);

      // illegal accesses
      wr(12'hC00, 32'd5);
      check("plan_ro_write", {31'd0, csr_illegal_o, csr_rdata_o}, {31'd0, 1'b1, 32'd0});
      rd(12'hB05);
      check("plan_bad_hpm", {31'd0, csr_illegal_o, csr_rdata_o}, {31'd0, 1'b1, 32'd0});

      // write beats increment
      step(0, 1, 1, 2'b01, 12'hF02, 32'd100, 1, 2'b00);
      rd(12'hF02);
      check("plan_instret100", {32'd0, csr_rdata_o}, 64'd100);

      // reset drops an in-flight access
      step(1, 1, 0, 2'b10, 12'hF00, 32'd0, 0, 2'b00);
      idle(1, 0, 2'b00);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] wd;
         wd = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         step($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 2) == 0, 2'($urandom_range(1, 3)),
              addr_tbl[$urandom_range(0, 29)], wd,
              $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/kamus_csr_counters.md
Name: kamus_csr_counters

Overview:
Machine-mode counter/timer CSR unit for the kamus-v core: mcycle, minstret, mtime/mtimecmp and a parametrised bank of hardware performance counters with an inhibit register. It serves the CSR read/modify/write port driven from EX (CSRRW/CSRRS/CSRRC) and raises the machine timer interrupt. It generalises the fixed counter CSR set to configurable counter width, HPM count and timer prescale.

Parameters:
COUNTER_W, 64, counter width in bits, legal 33..64; bits at or above COUNTER_W read 0 and ignore writes.
NUM_HPM, 2, number of mhpmcounter3.. counters, legal 0..8.
TIME_DIV, 1, clk_i cycles per mtime tick, legal 1..256.

Ports:
clk_i  in  1  core clock
rst_i  in  1  synchronous active-high reset
csr_req_i  in  1  CSR access this cycle
csr_we_i  in  1  access performs a write (decoder clears it for RS/RC with zero operand)
csr_op_i  in  2  funct2_system_t: F2_CSRRW/F2_CSRRS/F2_CSRRC
csr_addr_i  in  12  CSR address
csr_wdata_i  in  32  operand (rs1 or zimm)
csr_rdata_o  out  32  old CSR value, registered
csr_valid_o  out  1  response pulse
csr_illegal_o  out  1  unknown address or write to read-only CSR
instr_retired_i  in  1  one instruction retired this cycle
hpm_event_i  in  max(NUM_HPM,1)  per-HPM increment event, bit i -> counter 3+i
timer_irq_o  out  1  machine timer interrupt, registered

Behaviour:
- Reset: all counters, mtime, prescaler, mcountinhibit = 0; mtimecmp = all ones; csr_rdata_o=0, csr_valid_o=0, csr_illegal_o=0, timer_irq_o=0. Reset mid-access drops the access; no response.
- Response latency 1: access in cycle N -> csr_valid_o=1 for exactly cycle N+1 with csr_rdata_o/csr_illegal_o; no backpressure, back-to-back accesses accepted every cycle.
- Read value = value at start of cycle N (pre-increment, pre-write).
- Write value: RW -> wdata; RS -> old|wdata; RC -> old&~wdata; applied at end of cycle N.
- Address map: mcycle/h F00/F80, mtime/h F01/F81, minstret/h F02/F82, mtimecmp/h 7C1/7C2, mcountinhibit 320, mhpmcounter3+i/h B03+i/B83+i; read-only shadows cycle/time/instret(h) C00-C02/C80-C82, hpmcounter C03+i/C83+i.
- Illegal: address not in map (incl. HPM index >= NUM_HPM), or csr_we_i=1 to Cxx shadow -> csr_illegal_o=1, csr_rdata_o=0, no state change.
- Low/high halves: low address = bits 31:0, high = bits COUNTER_W-1:32 zero-extended; write to one half leaves the other unchanged.
- Increment: mcycle +1 every cycle unless mcountinhibit[0]; minstret +1 when instr_retired_i unless [2]; HPM i +1 when hpm_event_i[i] unless [3+i]. mcountinhibit[1] and bits above 2+NUM_HPM hardwired 0.
- Write beats increment: counter written in cycle N does not also increment in cycle N (either half).
- Wrap: all-ones +1 -> 0 within COUNTER_W, no flag.
- Prescaler counts 0..TIME_DIV-1; mtime +1 in the cycle it wraps to 0; writing mtime does not reset prescaler.
- timer_irq_o(N+1) = (mtime >= mtimecmp) unsigned, evaluated on cycle-N register values; level, cleared only by raising mtimecmp or changing mtime.

Decomposition:
- kamus_pkg gains csr_e entries MCOUNTINHIBIT, MHPMCOUNTER3..10(H), HPMCOUNTER3..10(H) and a function csr_rmw(old, wdata, funct2_system_t).
- One sub-module kamus_csr_counter: COUNTER_W counter with inc, wr_lo, wr_hi, wdata; instantiated for mcycle, minstret, mtime and each HPM via generate.

Test Plan:
- Reset then CSRRS x0 to mcycle (F00) at cycle 10 -> rdata 9 (counting from reset release), valid 1 cycle, illegal 0.
- CSRRW F00 with 0xFFFFFFFF and F80 with 0xFFFFFFFF (COUNTER_W=64) -> two cycles later low reads 0x00000000/0x00000001 range, high rolls to 0 after wrap.
- Set mcountinhibit=0x5 -> mcycle and minstret frozen over 100 cycles with instr_retired_i=1; HPM3 still counts hpm_event_i[0] pulses (7 pulses -> 7).
- TIME_DIV=4, mtimecmp=3 -> timer_irq_o rises one cycle after mtime reaches 3 (cycle ~13); write mtimecmp=0xFFFFFFFF low/high -> irq drops next cycle.
- CSRRW C00 with csr_we_i=1 and read of B05 with NUM_HPM=2 -> csr_illegal_o=1, rdata 0, mcycle continues unaffected.
- Same-cycle write to minstret=100 with instr_retired_i=1 -> readback 100, not 101; prior read returns old value.
